// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: AHB-Lite master that disables a FIR, streams tap_count coefficients into its
// coefficient memory, then re-enables it. Optional tlast framing check: FIR_LOADER_TLAST_CHECK_EN.
module fir_coeff_loader #(
   parameter logic [31:0] COEFF_BASE = 32'h0000_0000,
   parameter logic [31:0] CTRL_ADDR  = 32'h0000_0800
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [10:0] tap_count,
   input  logic [15:0] rate,
   output logic        busy,
   output logic        done,
   output logic        error,
   input  logic [15:0] tdata_s,
   input  logic        tvalid_s,
   output logic        tready_s,
   input  logic        tlast_s,
   output logic [31:0] haddr_m,
   output logic [1:0]  htrans_m,
   output logic [2:0]  hsize_m,
   output logic [2:0]  hburst_m,
   output logic        hwrite_m,
   output logic [31:0] hwdata_m,
   input  logic        hready_m,
   input  logic        hresp_m
);

   localparam int unsigned CNT_W    = 11;
   localparam int unsigned COEFF_W  = 16;
   localparam int unsigned MAX_TAPS = 1024;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DIS_A,
      S_DIS_D,
      S_FETCH,
      S_WR_A,
      S_WR_D,
      S_EN_A,
      S_EN_D,
      S_ERR
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    tap_q;
   logic [15:0]         rate_q;
   logic [CNT_W-1:0]    idx;
   logic [COEFF_W-1:0]  coeff_q;

   logic [CNT_W-1:0]    idx_inc_c;
   logic                last_write_c;
   logic                tlast_bad_c;

   assign hburst_m     = 3'b000;
   assign idx_inc_c    = idx + CNT_W'(1);
   assign last_write_c = (idx_inc_c == tap_q);

   // Framing check: only the final accepted beat may carry tlast.
`ifdef FIR_LOADER_TLAST_CHECK_EN
   assign tlast_bad_c = (tlast_s != (idx == (tap_q - CNT_W'(1))));
`else
   logic unused_tlast;
   assign unused_tlast = tlast_s;
   assign tlast_bad_c  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         tap_q    <= '0;
         rate_q   <= '0;
         idx      <= '0;
         coeff_q  <= '0;
         haddr_m  <= '0;
         htrans_m <= HTRANS_IDLE;
         hsize_m  <= '0;
         hwrite_m <= 1'b0;
         hwdata_m <= '0;
         tready_s <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (tap_count > CNT_W'(MAX_TAPS)) begin
                     error <= 1'b1;
                  end else begin
                     tap_q    <= tap_count;
                     rate_q   <= rate;
                     idx      <= '0;
                     error    <= 1'b0;
                     busy     <= 1'b1;
                     state    <= S_DIS_A;
                     htrans_m <= HTRANS_NONSEQ;
                     haddr_m  <= CTRL_ADDR;
                     hsize_m  <= HSIZE_WORD;
                     hwrite_m <= 1'b1;
                  end
               end
            end

            S_DIS_A: begin
               htrans_m <= HTRANS_IDLE;
               hwrite_m <= 1'b0;
               hwdata_m <= 32'h0;
               state    <= S_DIS_D;
            end

            S_DIS_D: begin
               if (hresp_m) begin
                  htrans_m <= HTRANS_IDLE;
                  error    <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_ERR;
               end else if (hready_m) begin
                  if (tap_q == '0) begin
                     htrans_m <= HTRANS_NONSEQ;
                     haddr_m  <= CTRL_ADDR;
                     hsize_m  <= HSIZE_WORD;
                     hwrite_m <= 1'b1;
                     state    <= S_EN_A;
                  end else begin
                     tready_s <= 1'b1;
                     state    <= S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               if (tvalid_s) begin
                  tready_s <= 1'b0;
                  if (tlast_bad_c) begin
                     error <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_ERR;
                  end else begin
                     coeff_q  <= tdata_s;
                     htrans_m <= HTRANS_NONSEQ;
                     haddr_m  <= COEFF_BASE + 32'({idx, 1'b0});
                     hsize_m  <= HSIZE_HALF;
                     hwrite_m <= 1'b1;
                     state    <= S_WR_A;
                  end
               end
            end

            S_WR_A: begin
               htrans_m <= HTRANS_IDLE;
               hwrite_m <= 1'b0;
               hwdata_m <= {coeff_q, coeff_q};
               state    <= S_WR_D;
            end

            S_WR_D: begin
               if (hresp_m) begin
                  htrans_m <= HTRANS_IDLE;
                  error    <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_ERR;
               end else if (hready_m) begin
                  idx <= idx_inc_c;
                  if (last_write_c) begin
                     htrans_m <= HTRANS_NONSEQ;
                     haddr_m  <= CTRL_ADDR;
                     hsize_m  <= HSIZE_WORD;
                     hwrite_m <= 1'b1;
                     state    <= S_EN_A;
                  end else begin
                     tready_s <= 1'b1;
                     state    <= S_FETCH;
                  end
               end
            end

            S_EN_A: begin
               htrans_m <= HTRANS_IDLE;
               hwrite_m <= 1'b0;
               hwdata_m <= {rate_q, 15'h0, 1'b1};
               state    <= S_EN_D;
            end

            S_EN_D: begin
               if (hresp_m) begin
                  htrans_m <= HTRANS_IDLE;
                  error    <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_ERR;
               end else if (hready_m) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            // One-cycle landing state; the filter stays disabled.
            S_ERR: begin
               htrans_m <= HTRANS_IDLE;
               state    <= S_IDLE;
            end

            default: begin
               htrans_m <= HTRANS_IDLE;
               tready_s <= 1'b0;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: random AHB wait states and coefficient data checked against a
// write-list and latency model built from the block's programming rules.
`timescale 1ns/1ps
module tb_fir_coeff_loader;

   localparam logic [31:0] CTRL    = 32'h0000_0800;
   localparam int          MAX_CYC = 4000;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] data;
   } xfer_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [10:0] tap_count = '0;
   logic [15:0] rate = '0;
   logic        busy, done, error;
   logic [15:0] tdata_s = '0;
   logic        tvalid_s = 1'b0;
   logic        tready_s;
   logic        tlast_s = 1'b0;
   logic [31:0] haddr_m;
   logic [1:0]  htrans_m;
   logic [2:0]  hsize_m;
   logic [2:0]  hburst_m;
   logic        hwrite_m;
   logic [31:0] hwdata_m;
   logic        hready_m = 1'b1;
   logic        hresp_m = 1'b0;

   fir_coeff_loader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .tap_count(tap_count), .rate(rate),
      .busy(busy), .done(done), .error(error),
      .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tready_s(tready_s), .tlast_s(tlast_s),
      .haddr_m(haddr_m), .htrans_m(htrans_m), .hsize_m(hsize_m), .hburst_m(hburst_m),
      .hwrite_m(hwrite_m), .hwdata_m(hwdata_m), .hready_m(hready_m), .hresp_m(hresp_m)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   xfer_t       seen_q[$];
   xfer_t       exp_q[$];
   int          wait_q[$];
   logic [16:0] src_q[$];
   logic [15:0] dat_q[$];
   int          exp_wait;
   int          err_at = -1;
   int          xfer_idx = 0;
   int          nonseq_cnt = 0;
   int          proto_err = 0;
   int          src_hold = 0;
   int          consumed = 0;
   logic        beat_taken = 1'b0;

   // AHB slave/monitor: records completed writes, inserts wait states and error responses.
   xfer_t cur;
   logic  dp_active = 1'b0;
   logic  cur_err = 1'b0;
   logic  prev_nonseq = 1'b0;
   int    wait_left = 0;
   always @(negedge clk) begin
      logic in_dp;
      if (!reset_n) begin
         dp_active   = 1'b0;
         prev_nonseq = 1'b0;
         hready_m    = 1'b1;
         hresp_m     = 1'b0;
      end else begin
         in_dp    = dp_active;
         hready_m = 1'b1;
         hresp_m  = 1'b0;
         if (htrans_m == 2'b10) begin
            nonseq_cnt++;
            if (in_dp || prev_nonseq || hwrite_m !== 1'b1 || hburst_m !== 3'b000) proto_err++;
            cur.addr  = haddr_m;
            cur.size  = hsize_m;
            cur.data  = '0;
            cur_err   = (xfer_idx == err_at);
            xfer_idx++;
            wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
         end else if (htrans_m !== 2'b00) begin
            proto_err++;
         end
         if (in_dp) begin
            if (wait_left > 0) begin
               hready_m = 1'b0;
               wait_left--;
            end else if (cur_err) begin
               hresp_m   = 1'b1;
               hready_m  = 1'b0;
               dp_active = 1'b0;
            end else begin
               cur.data  = hwdata_m;
               seen_q.push_back(cur);
               dp_active = 1'b0;
            end
         end
         if (htrans_m == 2'b10) dp_active = 1'b1;
         prev_nonseq = (htrans_m == 2'b10);
      end
   end

   // Stream source: beats from src_q, garbage data whenever tvalid is low.
   always @(negedge clk) begin
      logic [16:0] popped;
      if (beat_taken && src_q.size() > 0) begin
         popped = src_q.pop_front();
         consumed++;
      end
      if (src_hold > 0) begin
         tvalid_s = 1'b0;
         src_hold--;
      end else if (src_q.size() > 0) begin
         tvalid_s = 1'b1;
         {tlast_s, tdata_s} = src_q[0];
      end else begin
         tvalid_s = 1'b0;
      end
      if (!tvalid_s) begin
         tdata_s = 16'($urandom);
         tlast_s = 1'($urandom);
      end
      beat_taken = tvalid_s && tready_s && reset_n;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_htrans"}, 64'(htrans_m), 64'd0);
      check({tag, "_haddr"},  64'(haddr_m),  64'd0);
      check({tag, "_hsize"},  64'(hsize_m),  64'd0);
      check({tag, "_hwrite"}, 64'(hwrite_m), 64'd0);
      check({tag, "_hwdata"}, 64'(hwdata_m), 64'd0);
      check({tag, "_tready"}, 64'(tready_s), 64'd0);
      check({tag, "_busy"},   64'(busy),     64'd0);
      check({tag, "_done"},   64'(done),     64'd0);
      check({tag, "_error"},  64'(error),    64'd0);
   endtask

   task automatic prep(input int n, input int wmin, input int wmax, input int hold);
      int w;
      seen_q.delete(); wait_q.delete(); src_q.delete(); dat_q.delete(); exp_q.delete();
      beat_taken = 1'b0; consumed = 0; xfer_idx = 0; err_at = -1;
      nonseq_cnt = 0; proto_err = 0; exp_wait = 0;
      for (int i = 0; i < n + 2; i++) begin
         w = int'($urandom_range(wmax, wmin));
         wait_q.push_back(w);
         exp_wait += w;
      end
      for (int i = 0; i < n; i++) begin
         dat_q.push_back(16'($urandom));
         src_q.push_back({1'(i == n - 1), dat_q[i]});
      end
      src_hold = hold;
   endtask

   task automatic set_beat(input int i, input logic [15:0] d, input logic last);
      dat_q[i] = d;
      src_q[i] = {last, d};
   endtask

   // Model: disable, N halfword writes at 2*i with replicated data, then enable with rate.
   task automatic build_exp(input int n, input logic [15:0] r);
      exp_q.delete();
      exp_q.push_back('{CTRL, 3'b010, 32'h0});
      for (int i = 0; i < n; i++) exp_q.push_back('{32'(2 * i), 3'b001, {dat_q[i], dat_q[i]}});
      exp_q.push_back('{CTRL, 3'b010, {r, 15'h0, 1'b1}});
   endtask

   task automatic cmp_writes(input string tag, input int cnt);
      check({tag, "_nwr"}, 64'(seen_q.size()), 64'(cnt));
      for (int i = 0; i < cnt && i < seen_q.size(); i++) begin
         check($sformatf("%s_wr%0d_ad", tag, i), {seen_q[i].addr, seen_q[i].data},
               {exp_q[i].addr, exp_q[i].data});
         check($sformatf("%s_wr%0d_sz", tag, i), 64'(seen_q[i].size), 64'(exp_q[i].size));
      end
   endtask

   task automatic launch(input logic [10:0] n, input logic [15:0] r);
      start = 1'b1; tap_count = n; rate = r;
      step();
      start = 1'b0; tap_count = 11'($urandom); rate = 16'($urandom);
   endtask

   task automatic wait_end(input int poke, output int cyc, output logic ok);
      ok = 1'b0; cyc = 1;
      while (!ok && cyc < MAX_CYC) begin
         if (done || error) ok = 1'b1;
         else begin
            if (cyc == poke) begin start = 1'b1; tap_count = 11'd1025; end
            step();
            start = 1'b0;
            cyc++;
         end
      end
   endtask

   task automatic full_load(input string tag, input int n, input logic [15:0] r,
                            input int stall, input int poke);
      int   cyc;
      logic ok;
      build_exp(n, r);
      launch(11'(n), r);
      check({tag, "_busy1"}, 64'(busy), 64'd1);
      check({tag, "_err1"},  64'(error), 64'd0);
      wait_end(poke, cyc, ok);
      check({tag, "_finished"}, 64'(ok), 64'd1);
      check({tag, "_done"},  64'(done), 64'd1);
      check({tag, "_cycle"}, 64'(cyc), 64'(5 + 3 * n + exp_wait + stall));
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      check({tag, "_err_end"},  64'(error), 64'd0);
      cmp_writes(tag, n + 2);
      check({tag, "_beats"}, 64'(consumed), 64'(n));
      check({tag, "_proto"}, 64'(proto_err), 64'd0);
      step();
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc;
      logic ok;
      int   n;
      logic [15:0] r;

      repeat (3) step();
      check_reset("reset");
      reset_n = 1'b1;
      step();

      prep(4, 0, 0, 0);
      set_beat(0, 16'h1111, 1'b0); set_beat(1, 16'h2222, 1'b0);
      set_beat(2, 16'h3333, 1'b0); set_beat(3, 16'h4444, 1'b1);
      full_load("happy", 4, 16'h0020, 0, 0);

      prep(4, 2, 2, 0);
      set_beat(0, 16'h1111, 1'b0); set_beat(1, 16'h2222, 1'b0);
      set_beat(2, 16'h3333, 1'b0); set_beat(3, 16'h4444, 1'b1);
      full_load("wait", 4, 16'h0020, 0, 0);

      prep(0, 0, 0, 0);
      full_load("tap0", 0, 16'hBEEF, 0, 0);

      prep(0, 0, 0, 0);
      launch(11'd1025, 16'h1234);
      check("over_err", 64'(error), 64'd1);
      check("over_busy", 64'(busy), 64'd0);
      repeat (8) step();
      check("over_nonseq", 64'(nonseq_cnt), 64'd0);
      check("over_err_hold", 64'(error), 64'd1);

      for (int k = 0; k < 6; k++) begin
         n = int'($urandom_range(12, 1));
         r = 16'($urandom);
         prep(n, 0, 2, 0);
         full_load($sformatf("rand%0d", k), n, r, 0, 0);
      end

      prep(4, 0, 0, 0);
      err_at = 2;
      r = 16'($urandom);
      build_exp(4, r);
      launch(11'd4, r);
      wait_end(0, cyc, ok);
      check("berr_finished", 64'(ok), 64'd1);
      check("berr_cycle", 64'(cyc), 64'd9);
      check("berr_error", 64'(error), 64'd1);
      check("berr_busy", 64'(busy), 64'd0);
      check("berr_done", 64'(done), 64'd0);
      cmp_writes("berr", 2);
      check("berr_beats", 64'(consumed), 64'd2);
      repeat (6) step();
      check("berr_nonseq", 64'(nonseq_cnt), 64'd3);
      check("berr_nwr_late", 64'(seen_q.size()), 64'd2);
      check("berr_err_hold", 64'(error), 64'd1);

      prep(3, 0, 0, 6);
      full_load("stall", 3, 16'($urandom), 4, 6);

      prep(4, 0, 0, 0);
      r = 16'($urandom);
      build_exp(4, r);
      launch(11'd4, r);
      cyc = 1;
      while (seen_q.size() < 3 && cyc < 200) begin
         step();
         cyc++;
      end
      check("rst_reach", 64'(seen_q.size()), 64'd3);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset("rst_mid");
      step();
      src_q.delete();
      reset_n = 1'b1;
      repeat (4) step();
      check("rst_nonseq", 64'(nonseq_cnt), 64'd3);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_tready", 64'(tready_s), 64'd0);

      prep(4, 0, 0, 0);
      set_beat(1, dat_q[1], 1'b1);
`ifdef FIR_LOADER_TLAST_CHECK_EN
      build_exp(4, 16'h0020);
      launch(11'd4, 16'h0020);
      wait_end(0, cyc, ok);
      check("tlast_finished", 64'(ok), 64'd1);
      check("tlast_cycle", 64'(cyc), 64'd7);
      check("tlast_error", 64'(error), 64'd1);
      check("tlast_busy", 64'(busy), 64'd0);
      repeat (4) step();
      cmp_writes("tlast", 2);
      check("tlast_beats", 64'(consumed), 64'd2);
`else
      full_load("tlast", 4, 16'h0020, 0, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
